// File: rtl/dff_bist_checker.sv
// Purpose : BIST driver/checker for one D flip-flop; drives an LFSR bit stream on d_out,
//           predicts q/q_bar one clock later, counts mismatching vectors, reports pass/fail.
// Latency : done rises on edge t0+N_VECTORS+1 after the start edge t0; d_out is combinational from state.
// Backpressure: none; start is sampled only in IDLE/DONE and ignored while busy.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   start                     begin a run (IDLE/DONE only; held high restarts on every DONE)
//   d_out                     stimulus to the flip-flop's d (lfsr[0] in RUN, else 0)
//   q_in, q_bar_in            flip-flop q / q_bar responses
//   busy, done, pass          RUN|CHECK, DONE level, DONE with zero errors
//   err_cnt [ERR_W-1:0]       saturating count of mismatching vectors in current/last run
//   first_err_idx [7:0]       only with DFF_BIST_FIRST_ERR_EN: index of first failing vector, 8'hFF if none
//
// Build option: define DFF_BIST_FIRST_ERR_EN to add first_err_idx and its capture logic.

module dff_bist_checker #(
   parameter int          N_VECTORS = 16,
   parameter logic [7:0]  LFSR_SEED = 8'hA5,
   parameter int          ERR_W     = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   output logic             d_out,
   input  logic             q_in,
   input  logic             q_bar_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt
`ifdef DFF_BIST_FIRST_ERR_EN
   ,
   output logic [7:0]       first_err_idx
`endif
);

   // vec_cnt must reach N_VECTORS (it counts one past the last vector on the final RUN edge)
   localparam int unsigned VW = $clog2(N_VECTORS + 1);
   localparam logic [VW-1:0] LAST_VEC = VW'(N_VECTORS - 1);
   // An all-zero Fibonacci LFSR would lock up, so a zero seed is replaced
   localparam logic [7:0] SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
   localparam logic [ERR_W-1:0] ERR_MAX = '1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [7:0]    lfsr;
   logic          exp_bit;
   logic          cmp_vld;
   logic [VW-1:0] vec_cnt;
   logic          start_run;
   logic          cmp_en;
   logic          mismatch;
   logic [7:0]    lfsr_next;

   assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

   // The flip-flop under test returns last cycle's d_out, held in exp_bit.
   // A vector counts once even if both q and q_bar are wrong.
   assign mismatch = (q_in != exp_bit) | (q_bar_in != ~exp_bit);

   // First RUN edge has nothing to compare yet (cmp_vld=0); CHECK compares the final vector
   assign cmp_en = ((state_q == ST_RUN) && cmp_vld) || (state_q == ST_CHECK);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      start_run = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d   = ST_RUN;
               start_run = 1'b1;
            end
         end
         ST_RUN: begin
            if (vec_cnt == LAST_VEC) begin
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lfsr    <= 8'h00;
         exp_bit <= 1'b0;
         cmp_vld <= 1'b0;
         vec_cnt <= '0;
         err_cnt <= '0;
      end else begin
         if (start_run) begin
            lfsr    <= SEED_EFF;
            vec_cnt <= '0;
            err_cnt <= '0;
            cmp_vld <= 1'b0;
         end else begin
            if (state_q == ST_RUN) begin
               lfsr    <= lfsr_next;
               exp_bit <= lfsr[0];
               cmp_vld <= 1'b1;
               vec_cnt <= vec_cnt + VW'(1);
            end else if (state_q == ST_CHECK) begin
               cmp_vld <= 1'b0;
            end
            if (cmp_en && mismatch && (err_cnt != ERR_MAX)) begin
               err_cnt <= err_cnt + ERR_W'(1);
            end
         end
      end
   end

`ifdef DFF_BIST_FIRST_ERR_EN
   // vec_cnt is already one ahead of the vector being compared, both in RUN and in CHECK
   logic [VW-1:0] cmp_idx;
   assign cmp_idx = vec_cnt - VW'(1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         first_err_idx <= 8'hFF;
      end else if (start_run) begin
         first_err_idx <= 8'hFF;
      end else if (cmp_en && mismatch && (first_err_idx == 8'hFF)) begin
         first_err_idx <= 8'(cmp_idx);
      end
   end
`endif

   assign busy  = (state_q == ST_RUN) || (state_q == ST_CHECK);
   assign done  = (state_q == ST_DONE);
   assign pass  = done && (err_cnt == '0);
   assign d_out = (state_q == ST_RUN) ? lfsr[0] : 1'b0;

endmodule

// File: tb/tb_dff_bist_checker.sv
// Purpose : directed bench for dff_bist_checker with a behavioural flip-flop and fault injection.
// Two checkers run side by side: ERR_W=8 and ERR_W=2 (saturation), each looped to its own flip-flop.
// The d_out stream from seed 8'hA5 (vector 0 in bit 0) is 16'h6EE5, containing ten 1s.

module tb_dff_bist_checker;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start;
   logic       d_out, q_in, q_bar_in, busy, done, pass;
   logic [7:0] err_cnt;
   logic       d_out2, q_in2, q_bar_in2, busy2, done2, pass2;
   logic [1:0] err_cnt2;
`ifdef DFF_BIST_FIRST_ERR_EN
   logic [7:0] first_err_idx;
   logic [7:0] first_err_idx2;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int mode  = 0;

   logic q_reg  = 1'b0;
   logic q_reg2 = 1'b0;

   always #5 clk = ~clk;

   // Behavioural flip-flops under test
   always @(posedge clk) begin
      q_reg  <= d_out;
      q_reg2 <= d_out2;
   end

   // 0 ideal, 1 q_bar tied to q, 2 q=0/q_bar=1, 3 q=1/q_bar=0, 4 q_bar stuck 0
   function automatic logic [1:0] fault(input int m, input logic q);
      case (m)
         1:       return {q, q};
         2:       return 2'b01;
         3:       return 2'b10;
         4:       return {q, 1'b0};
         default: return {q, ~q};
      endcase
   endfunction

   assign {q_in,  q_bar_in}  = fault(mode, q_reg);
   assign {q_in2, q_bar_in2} = fault(mode, q_reg2);

   dff_bist_checker #(.N_VECTORS(16), .LFSR_SEED(8'hA5), .ERR_W(8)) u_dut (
      .clk(clk), .reset_n(reset_n), .start(start), .d_out(d_out),
      .q_in(q_in), .q_bar_in(q_bar_in), .busy(busy), .done(done),
      .pass(pass), .err_cnt(err_cnt)
`ifdef DFF_BIST_FIRST_ERR_EN
      , .first_err_idx(first_err_idx)
`endif
   );

   dff_bist_checker #(.N_VECTORS(16), .LFSR_SEED(8'hA5), .ERR_W(2)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .start(start), .d_out(d_out2),
      .q_in(q_in2), .q_bar_in(q_bar_in2), .busy(busy2), .done(done2),
      .pass(pass2), .err_cnt(err_cnt2)
`ifdef DFF_BIST_FIRST_ERR_EN
      , .first_err_idx(first_err_idx2)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Pulse start, then watch negedges: edges = posedges after the start edge until done is seen.
   task automatic run(input bit repulse, output int edges, output logic [15:0] bits,
                      output logic busy0);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      edges = 0;
      bits  = '0;
      busy0 = 1'b0;
      while (edges < 40) begin
         @(negedge clk);
         if (edges == 0) begin
            start = 1'b0;
            busy0 = busy;
         end
         if (repulse && edges == 5) start = 1'b1;
         if (repulse && edges == 6) start = 1'b0;
         if (edges < 16) bits[edges] = d_out;
         if (done) break;
         @(posedge clk);
         edges++;
      end
   endtask

   typedef struct {
      int         mode;
      logic [7:0] err;
      logic       pass;
      logic [1:0] err2;
      logic [7:0] first;
   } vec_t;

   vec_t        vecs[5];
   int          edges;
   logic [15:0] bits;
   logic        busy0;
   int          wait_cnt;

   initial begin
      vecs[0] = '{0,  8'd0, 1'b1, 2'd0, 8'hFF};
      vecs[1] = '{1, 8'd16, 1'b0, 2'd3, 8'd0};
      vecs[2] = '{2, 8'd10, 1'b0, 2'd3, 8'd0};
      vecs[3] = '{3,  8'd6, 1'b0, 2'd3, 8'd1};
      vecs[4] = '{4,  8'd6, 1'b0, 2'd3, 8'd1};

      reset_n = 1'b1;
      start   = 1'b0;
      #2 reset_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_d_out", d_out, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_err", err_cnt, 0);
      check("rst_err2", err_cnt2, 0);
`ifdef DFF_BIST_FIRST_ERR_EN
      check("rst_first", first_err_idx, 8'hFF);
`endif
      reset_n = 1'b1;

      for (int i = 0; i < 5; i++) begin
         mode = vecs[i].mode;
         run(1'b0, edges, bits, busy0);
         check($sformatf("v%0d_edges", i), edges, 17);
         check($sformatf("v%0d_busy", i), busy0, 1);
         check($sformatf("v%0d_bits", i), bits, 16'h6EE5);
         check($sformatf("v%0d_done", i), done, 1);
         check($sformatf("v%0d_err", i), err_cnt, vecs[i].err);
         check($sformatf("v%0d_pass", i), pass, vecs[i].pass);
         check($sformatf("v%0d_err2", i), err_cnt2, vecs[i].err2);
         check($sformatf("v%0d_pass2", i), pass2, (vecs[i].err2 == 0));
`ifdef DFF_BIST_FIRST_ERR_EN
         check($sformatf("v%0d_first", i), first_err_idx, vecs[i].first);
`endif
         repeat (3) @(negedge clk);
         check($sformatf("v%0d_hold_done", i), done, 1);
         check($sformatf("v%0d_hold_err", i), err_cnt, vecs[i].err);
      end

      // start re-pulsed mid-run is ignored
      mode = 2;
      run(1'b1, edges, bits, busy0);
      check("repulse_edges", edges, 17);
      check("repulse_err", err_cnt, 10);
      check("repulse_bits", bits, 16'h6EE5);

      // start held high: restarts each time DONE is reached
      mode = 1;
      @(negedge clk);
      start = 1'b1;
      wait_cnt = 0;
      do begin
         @(negedge clk);
         wait_cnt++;
      end while (!done && wait_cnt < 60);
      check("held_done1", done, 1);
      @(negedge clk);
      check("held_restart_busy", busy, 1);
      check("held_restart_done", done, 0);
      check("held_restart_err", err_cnt, 0);
      wait_cnt = 0;
      do begin
         @(negedge clk);
         wait_cnt++;
      end while (!done && wait_cnt < 60);
      start = 1'b0;
      check("held_done2", done, 1);
      check("held_err2", err_cnt, 16);

      // async reset in the middle of RUN
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("midrst_pre_err", err_cnt, 4);
      check("midrst_pre_err2", err_cnt2, 3);
      reset_n = 1'b0;
      #1;
      check("midrst_d_out", d_out, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_pass", pass, 0);
      check("midrst_err", err_cnt, 0);
      check("midrst_err2", err_cnt2, 0);
`ifdef DFF_BIST_FIRST_ERR_EN
      check("midrst_first", first_err_idx, 8'hFF);
`endif
      @(negedge clk);
      reset_n = 1'b1;
      mode = 0;
      run(1'b0, edges, bits, busy0);
      check("postrst_edges", edges, 17);
      check("postrst_bits", bits, 16'h6EE5);
      check("postrst_err", err_cnt, 0);
      check("postrst_pass", pass, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
